// File: rtl/extended_div.sv
// extended_div: multicycle radix-2 restoring divider for DIV (signed) / UDIV (unsigned).
// Operates on magnitudes and applies a final sign-fix cycle; results are held until the next accepted start.
`default_nettype none

module extended_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             func,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dv0,
  output logic             ov,
  output logic             zr,
  output logic             neg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic             qsign_q;
  logic             rsign_q;
  logic             ovf_q;
  logic             func_q;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_ovf;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  assign w_a_neg = ~func & src1[WIDTH-1];
  assign w_b_neg = ~func & src0[WIDTH-1];
  assign w_a_mag = w_a_neg ? -src1 : src1;
  assign w_b_mag = w_b_neg ? -src0 : src0;
  assign w_ovf   = ~func && (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src0 == {WIDTH{1'b1}});

  // The shifted partial remainder needs one extra bit; after a conditional
  // subtract it is always below the divisor and fits back into WIDTH bits.
  assign w_shift = {r_q, q_q[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, d_q});
  assign r_d     = w_ge ? (w_shift[WIDTH-1:0] - d_q) : w_shift[WIDTH-1:0];
  assign q_d     = {q_q[WIDTH-2:0], w_ge};

  assign w_quot_fix = qsign_q ? -q_q : q_q;
  assign w_rem_fix  = rsign_q ? -r_q : r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      ovf_q   <= 1'b0;
      func_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      quot    <= '0;
      rem     <= '0;
      dv0     <= 1'b0;
      ov      <= 1'b0;
      zr      <= 1'b0;
      neg     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            func_q <= func;
            busy   <= 1'b1;
            if (src0 == '0) begin
              quot    <= '1;
              rem     <= src1;
              dv0     <= 1'b1;
              ov      <= 1'b0;
              zr      <= 1'b0;
              neg     <= ~func;
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              r_q     <= '0;
              q_q     <= w_a_mag;
              d_q     <= w_b_mag;
              qsign_q <= w_a_neg ^ w_b_neg;
              rsign_q <= w_a_neg;
              ovf_q   <= w_ovf;
              cnt_q   <= CNT_INIT;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          quot    <= w_quot_fix;
          rem     <= w_rem_fix;
          ov      <= ovf_q;
          zr      <= (w_quot_fix == '0);
          neg     <= ~func_q & w_quot_fix[WIDTH-1];
          dv0     <= 1'b0;
          done    <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_extended_div.sv
// tb_extended_div: directed-vector self-checking bench for extended_div.
`default_nettype none

module tb_extended_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        func = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src0 = '0;
  logic        busy, done, dv0, ov, zr, neg;
  logic [31:0] quot, rem;

  int n_cmp = 0;
  int n_fail = 0;

  extended_div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .src1(src1), .src0(src0),
    .busy(busy), .done(done), .quot(quot), .rem(rem),
    .dv0(dv0), .ov(ov), .zr(zr), .neg(neg)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait for done; lat counts edges after the accept edge.
  task automatic do_op(input logic f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy_ok);
    @(negedge clk);
    func = f; src1 = a; src0 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; src1 = ~a; src0 = ~b; func = ~f;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (quot !== 32'h0) begin n_fail++; $display("FAIL reset_quot: got %h want 0", quot); end
    n_cmp++; if (rem !== 32'h0) begin n_fail++; $display("FAIL reset_rem: got %h want 0", rem); end
    n_cmp++; if ({dv0, ov, zr, neg} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {dv0, ov, zr, neg}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat; logic bok;
    do_op(1'b0, 32'd100, 32'd7, lat, bok);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy_window: got %b want 1", bok); end
    n_cmp++; if (quot !== 32'd14) begin n_fail++; $display("FAIL basic_quot: got %h want %h", quot, 32'd14); end
    n_cmp++; if (rem !== 32'd2) begin n_fail++; $display("FAIL basic_rem: got %h want %h", rem, 32'd2); end
    n_cmp++; if ({dv0, ov, zr, neg} !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b want 0000", {dv0, ov, zr, neg}); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    n_cmp++; if (quot !== 32'd14) begin n_fail++; $display("FAIL basic_hold: got %h want %h", quot, 32'd14); end
  endtask

  task automatic test_signed();
    int lat; logic bok;
    do_op(1'b0, 32'hFFFF_FF9C, 32'd7, lat, bok);
    n_cmp++; if (quot !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL sneg_quot: got %h want fffffff2", quot); end
    n_cmp++; if (rem !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sneg_rem: got %h want fffffffe", rem); end
    n_cmp++; if ({zr, neg} !== 2'b01) begin n_fail++; $display("FAIL sneg_flags: got %b want 01", {zr, neg}); end
    do_op(1'b0, 32'd100, 32'hFFFF_FFF9, lat, bok);
    n_cmp++; if (quot !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL sdivneg_quot: got %h want fffffff2", quot); end
    n_cmp++; if (rem !== 32'd2) begin n_fail++; $display("FAIL sdivneg_rem: got %h want 2", rem); end
  endtask

  task automatic test_unsigned();
    int lat; logic bok;
    do_op(1'b1, 32'hFFFF_FFFF, 32'd2, lat, bok);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL udiv_latency: got %0d want 33", lat); end
    n_cmp++; if (quot !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL udiv_quot: got %h want 7fffffff", quot); end
    n_cmp++; if (rem !== 32'd1) begin n_fail++; $display("FAIL udiv_rem: got %h want 1", rem); end
    n_cmp++; if ({zr, neg} !== 2'b00) begin n_fail++; $display("FAIL udiv_flags: got %b want 00", {zr, neg}); end
    do_op(1'b0, 32'hFFFF_FFFF, 32'd2, lat, bok);
    n_cmp++; if (quot !== 32'h0) begin n_fail++; $display("FAIL sdiv_m1_quot: got %h want 0", quot); end
    n_cmp++; if (rem !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdiv_m1_rem: got %h want ffffffff", rem); end
    n_cmp++; if ({zr, neg} !== 2'b10) begin n_fail++; $display("FAIL sdiv_m1_flags: got %b want 10", {zr, neg}); end
  endtask

  task automatic test_div0();
    int lat; logic bok;
    do_op(1'b0, 32'h1234_5678, 32'h0, lat, bok);
    n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL dv0_latency: got %0d want 0", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_fail++; $display("FAIL dv0_busy: got %b want 1", bok); end
    n_cmp++; if (quot !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dv0_quot: got %h want ffffffff", quot); end
    n_cmp++; if (rem !== 32'h1234_5678) begin n_fail++; $display("FAIL dv0_rem: got %h want 12345678", rem); end
    n_cmp++; if ({dv0, ov, zr, neg} !== 4'b1001) begin n_fail++; $display("FAIL dv0_flags: got %b want 1001", {dv0, ov, zr, neg}); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL dv0_done_pulse: got %b want 00", {done, busy}); end
    do_op(1'b0, 32'd10, 32'd3, lat, bok);
    n_cmp++; if ({quot, rem} !== {32'd3, 32'd1}) begin n_fail++; $display("FAIL dv0_next_result: got %h/%h want 3/1", quot, rem); end
    n_cmp++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL dv0_clear: got %b want 0", dv0); end
  endtask

  task automatic test_overflow();
    int lat; logic bok;
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    n_cmp++; if (quot !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_quot: got %h want 80000000", quot); end
    n_cmp++; if (rem !== 32'h0) begin n_fail++; $display("FAIL ovf_rem: got %h want 0", rem); end
    n_cmp++; if ({dv0, ov, zr, neg} !== 4'b0101) begin n_fail++; $display("FAIL ovf_flags: got %b want 0101", {dv0, ov, zr, neg}); end
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    n_cmp++; if (quot !== 32'h0) begin n_fail++; $display("FAIL uovf_quot: got %h want 0", quot); end
    n_cmp++; if (rem !== 32'h8000_0000) begin n_fail++; $display("FAIL uovf_rem: got %h want 80000000", rem); end
    n_cmp++; if ({dv0, ov, zr, neg} !== 4'b0010) begin n_fail++; $display("FAIL uovf_flags: got %b want 0010", {dv0, ov, zr, neg}); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    func = 1'b0; src1 = 32'd1000; src0 = 32'd10; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    func = 1'b0; src1 = 32'd5; src0 = 32'd5; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    lat = 10;
    while (!done && lat < 100) begin @(posedge clk); @(negedge clk); lat++; end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    n_cmp++; if ({quot, rem} !== {32'd100, 32'd0}) begin n_fail++; $display("FAIL ignore_result: got %h/%h want 64/0", quot, rem); end
    // start raised while done is high must not be accepted
    src1 = 32'd6; src0 = 32'd3; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_start_ignored: got busy %b want 0", busy); end
  endtask

  task automatic test_abort();
    int lat; logic bok; logic seen_done;
    @(negedge clk);
    func = 1'b0; src1 = 32'd1000; src0 = 32'd10; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (14) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({busy, done, dv0, ov, zr, neg} !== 6'b0) begin n_fail++; $display("FAIL abort_flags: got %b want 000000", {busy, done, dv0, ov, zr, neg}); end
    n_cmp++; if ({quot, rem} !== 64'h0) begin n_fail++; $display("FAIL abort_data: got %h/%h want 0/0", quot, rem); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin @(negedge clk); if (done || busy) seen_done = 1'b1; end
    n_cmp++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", seen_done); end
    do_op(1'b0, 32'd1000, 32'd10, lat, bok);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL abort_recover_latency: got %0d want 33", lat); end
    n_cmp++; if ({quot, rem} !== {32'd100, 32'd0}) begin n_fail++; $display("FAIL abort_recover_result: got %h/%h want 64/0", quot, rem); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_unsigned();
    test_div0();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
